// File: rtl/div_mod_sequencer.sv
// div_mod_sequencer: multi-cycle unsigned restoring DIV/MOD unit with pipeline stall handshake.
// One quotient bit per cycle; divide-by-zero finishes in a single cycle with a flagged result.
module div_mod_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Start,
    input  logic [2:0]       ALUControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             Stall,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic             DivZero
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] rem_q, quo_q, div_q, result_q;
    logic [CW-1:0]    cnt_q;
    logic             mod_q, dz_q;
    logic             valid_start, ge;
    logic [WIDTH:0]   shifted, diff;
    logic [WIDTH-1:0] rem_d, quo_d;

    assign valid_start = Start && (ALUControl == 3'b011 || ALUControl == 3'b100);

    // quo_q doubles as the dividend shift register: its MSB feeds the remainder each step
    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign diff    = shifted - {1'b0, div_q};
    assign ge      = shifted >= {1'b0, div_q};
    assign rem_d   = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign quo_d   = {quo_q[WIDTH-2:0], ge};

    assign Stall   = (state_q == IDLE && valid_start) || state_q == CALC;
    assign Busy    = state_q != IDLE;
    assign Done    = state_q == DONE;
    assign Result  = result_q;
    assign DivZero = dz_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            quo_q    <= '0;
            div_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            mod_q    <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (valid_start) begin
                    div_q <= SrcB;
                    quo_q <= SrcA;
                    rem_q <= '0;
                    mod_q <= ALUControl == 3'b100;
                    if (SrcB == '0) begin
                        result_q <= (ALUControl == 3'b100) ? SrcA : '1;
                        dz_q     <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        dz_q    <= 1'b0;
                        cnt_q   <= CW'(WIDTH);
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        result_q <= mod_q ? rem_d : quo_d;
                        state_q  <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/div_mod_sequencer.md
DIV_MOD_SEQUENCER -- requirements
Module: div_mod_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the datapath operand width.
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 The block SHALL have port Start, input, 1, request from decode to begin a DIV/MOD operation.
REQ-005 The block SHALL have port ALUControl, input, 3, operation select: 3'b011 DIV, 3'b100 MOD, any other value invalid.
REQ-006 The block SHALL have port SrcA, input, WIDTH, unsigned dividend.
REQ-007 The block SHALL have port SrcB, input, WIDTH, unsigned divisor.
REQ-008 The block SHALL have port Stall, output, 1, freeze request to the pipeline front end.
REQ-009 The block SHALL have port Busy, output, 1, high while an operation is in progress.
REQ-010 The block SHALL have port Done, output, 1, one-cycle result-valid pulse.
REQ-011 The block SHALL have port Result, output, WIDTH, quotient (DIV) or remainder (MOD).
REQ-012 The block SHALL have port DivZero, output, 1, flag marking that the completed operation had SrcB == 0.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, CALC, DONE.
REQ-014 A valid start SHALL be Start=1 with ALUControl in {011, 100}, sampled only in IDLE; any other Start SHALL be ignored.
REQ-015 On a valid start, the block SHALL latch SrcA, SrcB and the op select into internal registers on the same edge; later input changes SHALL NOT affect the operation.
REQ-016 A valid start with SrcB != 0 SHALL move IDLE->CALC, clear the partial remainder, and load the iteration counter with WIDTH.
REQ-017 In CALC, each cycle SHALL perform one restoring-division step (shift remainder left, bring in next dividend MSB, subtract divisor if remainder >= divisor, set quotient bit) and decrement the counter.
REQ-018 When the counter reaches 0, CALC->DONE SHALL occur on that edge, so Done is high exactly WIDTH edges after the sampling edge.
REQ-019 A valid start with SrcB == 0 SHALL move IDLE->DONE directly; Result SHALL be all-ones for DIV or the latched SrcA for MOD, and DivZero SHALL be 1.
REQ-020 DONE SHALL last exactly one cycle and then go to IDLE unconditionally; Start asserted during DONE SHALL be ignored.
REQ-021 In DONE, Done SHALL be 1; in all other states Done SHALL be 0.
REQ-022 Result and DivZero SHALL become valid in DONE and hold until the next valid start; DivZero SHALL clear on a valid start with SrcB != 0.
REQ-023 Busy SHALL be 1 in CALC and DONE and 0 in IDLE.
REQ-024 Stall SHALL be combinational: 1 in IDLE while a valid start is present, 1 throughout CALC, 0 in DONE and otherwise.
REQ-025 All arithmetic SHALL be unsigned WIDTH-bit; the subtract SHALL use a WIDTH+1-bit comparison so no carry is lost.
REQ-026 Start and ALUControl changes while in CALC SHALL have no effect.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, Stall=0, Busy=0, Done=0, Result=0, DivZero=0, counter=0, independent of clk.
REQ-028 Reset asserted mid-CALC SHALL abort the operation without producing Done; after release, the block SHALL accept a new start from IDLE.

Verification
REQ-029 The bench SHALL apply DIV 100/7 (WIDTH=16) and require Result=14 with Done exactly 16 edges after the sampling edge, and Stall high during all of those cycles except the DONE cycle.
REQ-030 The bench SHALL apply MOD 100/7 and require Result=2, DivZero=0.
REQ-031 The bench SHALL apply DIV 5/0 then MOD 5/0 and require Done one edge after sampling, with Result=16'hFFFF and 5 respectively, and DivZero=1.
REQ-032 The bench SHALL apply DIV 16'hFFFF/1 and 3/16'hFFFF and require Result=16'hFFFF and 0 respectively.
REQ-033 The bench SHALL apply Start with ALUControl=3'b000, then Start held high through CALC and DONE, and require no new operation accepted and Stall=0 for the invalid op.
REQ-034 The bench SHALL pulse rst_n low at cycle 5 of a DIV and require immediate return to reset values, no Done, then a correct 9/3 -> 3 afterwards.
